// File: rtl/game_round_ctrl_if.sv
// Signal bundle between the game round controller and its input/judge/display neighbours.
// master drives the player-side inputs; slave is the controller itself.
interface game_round_ctrl_if #(
  parameter int HP_W = 3
);
  logic            START;
  logic            Q_READY;
  logic            ANS_TOG;
  logic            WRONG_IN;
  logic [1:0]      JUDGE_IN;
  logic [3:0]      STATE;
  logic [HP_W-1:0] HP_ME;
  logic [HP_W-1:0] HP_OPP;
  logic [7:0]      ROUND_CNT;
  logic            SHOWING;
  logic            TMO;

  modport master (
    output START, Q_READY, ANS_TOG, WRONG_IN, JUDGE_IN,
    input  STATE, HP_ME, HP_OPP, ROUND_CNT, SHOWING, TMO
  );

  modport slave (
    input  START, Q_READY, ANS_TOG, WRONG_IN, JUDGE_IN,
    output STATE, HP_ME, HP_OPP, ROUND_CNT, SHOWING, TMO
  );
endinterface

// File: rtl/game_round_ctrl.sv
// Round controller for the two-player factorisation game: state sequencing, HP, timed displays.
// Optional answer time limit is enabled by defining ANSWER_TIMEOUT_EN.
module game_round_ctrl #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SHOW_MS = 1000,
  parameter int HP_MAX  = 5,
  parameter int HP_W    = 3,
  parameter int DMG     = 1,
  parameter int ANS_MS  = 10000
) (
  input logic              CLK,
  input logic              RST,
  game_round_ctrl_if.slave bus
);

  localparam int SHOW_CYC = CLK_HZ / 1000 * SHOW_MS;
  localparam int SHOW_W   = $clog2(SHOW_CYC);
  localparam logic [SHOW_W-1:0] SHOW_LAST = SHOW_W'(SHOW_CYC - 1);
  localparam logic [HP_W-1:0]   HP_INIT   = HP_W'(HP_MAX);

  if (SHOW_CYC < 2 || HP_MAX >= (2 ** HP_W) || DMG < 0 || ANS_MS < 1) begin : g_bad_cfg
    $error("game_round_ctrl: illegal parameter combination");
  end

  typedef enum logic [3:0] {
    S_READY    = 4'd2,
    S_QUESTION = 4'd3,
    S_INPUT    = 4'd4,
    S_DRAW     = 4'd6,
    S_WRONG    = 4'd7,
    S_GOOD     = 4'd8,
    S_OUCH     = 4'd9,
    S_WIN      = 4'd10,
    S_LOSE     = 4'd11
  } state_e;

  state_e            state_q, state_d;
  logic [HP_W-1:0]   hp_me_q, hp_me_d;
  logic [HP_W-1:0]   hp_opp_q, hp_opp_d;
  logic [7:0]        round_q, round_d;
  logic [SHOW_W-1:0] show_cnt_q, show_cnt_d;
  logic              tog_prev_q, tog_prev_d;
  logic              tog;
  logic              showing;
  logic              show_done;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp);
    if (int'(hp) > DMG) return HP_W'(int'(hp) - DMG);
    else                return '0;
  endfunction

`ifdef ANSWER_TIMEOUT_EN
  localparam int ANS_CYC = CLK_HZ / 1000 * ANS_MS;
  localparam int ANS_W   = $clog2(ANS_CYC + 1);
  localparam logic [ANS_W-1:0] ANS_LAST = ANS_W'(ANS_CYC - 1);

  logic [ANS_W-1:0] ans_cnt_q, ans_cnt_d;
  logic             tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    hp_me_d    = hp_me_q;
    hp_opp_d   = hp_opp_q;
    round_d    = round_q;
    tog_prev_d = bus.ANS_TOG;
    tog        = bus.ANS_TOG != tog_prev_q;
    showing    = state_q inside {S_DRAW, S_WRONG, S_GOOD, S_OUCH, S_WIN, S_LOSE};
    show_done  = show_cnt_q == SHOW_LAST;
`ifdef ANSWER_TIMEOUT_EN
    tmo_d      = 1'b0;
`endif

    case (state_q)
      S_READY:    if (bus.START && bus.Q_READY) state_d = S_QUESTION;
      S_QUESTION: begin
        if (tog && bus.Q_READY)          state_d = S_INPUT;
        else if (bus.JUDGE_IN == 2'b10)  state_d = S_OUCH;
      end
      S_INPUT: begin
        if (tog)                         state_d = S_QUESTION;
        else if (bus.WRONG_IN)           state_d = S_WRONG;
        else if (bus.JUDGE_IN == 2'b01)  state_d = S_GOOD;
        else if (bus.JUDGE_IN == 2'b10)  state_d = S_OUCH;
        else if (bus.JUDGE_IN == 2'b11)  state_d = S_DRAW;
`ifdef ANSWER_TIMEOUT_EN
        else if (ans_cnt_q == ANS_LAST) begin
          state_d = S_OUCH;
          tmo_d   = 1'b1;
        end
`endif
      end
      S_WRONG:    if (show_done) state_d = S_INPUT;
      S_DRAW:     if (show_done) state_d = S_READY;
      // HP was already reduced on the entry edge, so the zero test sees the new value.
      S_GOOD:     if (show_done) state_d = (hp_opp_q == '0) ? S_WIN  : S_READY;
      S_OUCH:     if (show_done) state_d = (hp_me_q  == '0) ? S_LOSE : S_READY;
      S_WIN, S_LOSE: begin
        if (show_done) begin
          state_d  = S_READY;
          hp_me_d  = HP_INIT;
          hp_opp_d = HP_INIT;
          round_d  = '0;
        end
      end
      default:    state_d = S_READY;
    endcase

    if (state_d != state_q) begin
      case (state_d)
        S_GOOD: begin
          hp_opp_d = sat_sub(hp_opp_q);
          round_d  = round_q + 8'd1;
        end
        S_OUCH: begin
          hp_me_d  = sat_sub(hp_me_q);
          round_d  = round_q + 8'd1;
        end
        S_DRAW:  round_d = round_q + 8'd1;
        default: ;
      endcase
    end

    show_cnt_d = (state_d != state_q || !showing) ? '0 : show_cnt_q + 1'b1;
`ifdef ANSWER_TIMEOUT_EN
    ans_cnt_d  = (state_d != state_q || state_q != S_INPUT) ? '0 : ans_cnt_q + 1'b1;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_READY;
      hp_me_q    <= HP_INIT;
      hp_opp_q   <= HP_INIT;
      round_q    <= '0;
      show_cnt_q <= '0;
      tog_prev_q <= bus.ANS_TOG;
`ifdef ANSWER_TIMEOUT_EN
      ans_cnt_q  <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      hp_me_q    <= hp_me_d;
      hp_opp_q   <= hp_opp_d;
      round_q    <= round_d;
      show_cnt_q <= show_cnt_d;
      tog_prev_q <= tog_prev_d;
`ifdef ANSWER_TIMEOUT_EN
      ans_cnt_q  <= ans_cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign bus.STATE     = state_q;
  assign bus.HP_ME     = hp_me_q;
  assign bus.HP_OPP    = hp_opp_q;
  assign bus.ROUND_CNT = round_q;
  assign bus.SHOWING   = showing;
`ifdef ANSWER_TIMEOUT_EN
  assign bus.TMO       = tmo_q;
`else
  assign bus.TMO       = 1'b0;
`endif

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed scenarios plus randomized play against a rule-level model.
// Honours ANSWER_TIMEOUT_EN the same way the design does.
module tb_game_round_ctrl;

  localparam int CLK_HZ   = 1000;
  localparam int SHOW_MS  = 4;
  localparam int HP_MAX   = 2;
  localparam int HP_W     = 3;
  localparam int DMG      = 1;
  localparam int ANS_MS   = 8;
  localparam int SHOW_CYC = CLK_HZ / 1000 * SHOW_MS;
  localparam int ANS_CYC  = CLK_HZ / 1000 * ANS_MS;

  logic CLK = 1'b0;
  logic RST;
  int   n_chk  = 0;
  int   n_fail = 0;

  game_round_ctrl_if #(.HP_W(HP_W)) bus ();

  game_round_ctrl #(
    .CLK_HZ(CLK_HZ), .SHOW_MS(SHOW_MS), .HP_MAX(HP_MAX),
    .HP_W(HP_W), .DMG(DMG), .ANS_MS(ANS_MS)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Rule-level model: display states keep a "cycles left" countdown.
  int   m_state, m_hp_me, m_hp_opp, m_round, m_hold, m_ans, m_tmo;
  logic m_prev;

  task automatic enter(input int s);
    m_state = s;
    if (s >= 6) m_hold = SHOW_CYC;
    if (s == 4) m_ans = ANS_CYC;
    if (s == 8) begin
      m_hp_opp = (m_hp_opp > DMG) ? m_hp_opp - DMG : 0;
      m_round  = (m_round + 1) % 256;
    end
    if (s == 9) begin
      m_hp_me = (m_hp_me > DMG) ? m_hp_me - DMG : 0;
      m_round = (m_round + 1) % 256;
    end
    if (s == 6) m_round = (m_round + 1) % 256;
  endtask

  task automatic model_edge();
    logic t;
    if (RST) begin
      m_state = 2; m_hp_me = HP_MAX; m_hp_opp = HP_MAX; m_round = 0;
      m_hold = 0; m_ans = 0; m_tmo = 0; m_prev = bus.ANS_TOG;
      return;
    end
    t      = (bus.ANS_TOG != m_prev);
    m_prev = bus.ANS_TOG;
    m_tmo  = 0;
    if (m_state >= 6) begin
      if (m_hold > 1) m_hold--;
      else begin
        case (m_state)
          7: enter(4);
          6: enter(2);
          8: enter(m_hp_opp == 0 ? 10 : 2);
          9: enter(m_hp_me == 0 ? 11 : 2);
          default: begin
            m_hp_me = HP_MAX; m_hp_opp = HP_MAX; m_round = 0;
            enter(2);
          end
        endcase
      end
    end else begin
      case (m_state)
        2: if (bus.START && bus.Q_READY) enter(3);
        3: begin
          if (t && bus.Q_READY) enter(4);
          else if (bus.JUDGE_IN == 2) enter(9);
        end
        default: begin
          if (t) enter(3);
          else if (bus.WRONG_IN) enter(7);
          else if (bus.JUDGE_IN == 1) enter(8);
          else if (bus.JUDGE_IN == 2) enter(9);
          else if (bus.JUDGE_IN == 3) enter(6);
`ifdef ANSWER_TIMEOUT_EN
          else if (m_ans == 1) begin enter(9); m_tmo = 1; end
          else m_ans--;
`endif
        end
      endcase
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    n_chk++; if (bus.STATE !== 4'd2) begin n_fail++; $display("FAIL reset_state got=%0d exp=2", bus.STATE); end
    n_chk++; if (bus.HP_ME !== 3'd2 || bus.HP_OPP !== 3'd2) begin n_fail++; $display("FAIL reset_hp got=%0d/%0d exp=2/2", bus.HP_ME, bus.HP_OPP); end
    n_chk++; if (bus.ROUND_CNT !== 8'd0) begin n_fail++; $display("FAIL reset_round got=%0d exp=0", bus.ROUND_CNT); end
    n_chk++; if (bus.SHOWING !== 1'b0 || bus.TMO !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", bus.SHOWING, bus.TMO); end
  endtask

  task automatic go_input(input string tag);
    bus.START = 1'b1; bus.Q_READY = 1'b1;
    cycle();
    bus.START = 1'b0;
    n_chk++; if (bus.STATE !== 4'd3) begin n_fail++; $display("FAIL %s_question got=%0d exp=3", tag, bus.STATE); end
    bus.ANS_TOG = ~bus.ANS_TOG;
    cycle();
    n_chk++; if (bus.STATE !== 4'd4) begin n_fail++; $display("FAIL %s_input got=%0d exp=4", tag, bus.STATE); end
  endtask

  task automatic test_good_win();
    go_input("good1");
    bus.JUDGE_IN = 2'b01;
    cycle();
    bus.JUDGE_IN = 2'b00;
    n_chk++; if (bus.HP_OPP !== 3'd1 || bus.ROUND_CNT !== 8'd1) begin n_fail++; $display("FAIL good1_hp_round got=%0d/%0d exp=1/1", bus.HP_OPP, bus.ROUND_CNT); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (bus.STATE !== 4'd8 || bus.SHOWING !== 1'b1) begin n_fail++; $display("FAIL good1_hold[%0d] got=%0d/%b exp=8/1", i, bus.STATE, bus.SHOWING); end
      cycle();
    end
    n_chk++; if (bus.STATE !== 4'd2 || bus.HP_OPP !== 3'd1) begin n_fail++; $display("FAIL good1_exit got=%0d/%0d exp=2/1", bus.STATE, bus.HP_OPP); end

    go_input("good2");
    bus.JUDGE_IN = 2'b01;
    cycle();
    bus.JUDGE_IN = 2'b00;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (bus.STATE !== 4'd8 || bus.HP_OPP !== 3'd0) begin n_fail++; $display("FAIL good2_hold[%0d] got=%0d/%0d exp=8/0", i, bus.STATE, bus.HP_OPP); end
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (bus.STATE !== 4'd10) begin n_fail++; $display("FAIL win_hold[%0d] got=%0d exp=10", i, bus.STATE); end
      cycle();
    end
    n_chk++; if (bus.STATE !== 4'd2 || bus.HP_ME !== 3'd2 || bus.HP_OPP !== 3'd2 || bus.ROUND_CNT !== 8'd0) begin
      n_fail++; $display("FAIL win_reload got=%0d/%0d/%0d/%0d exp=2/2/2/0", bus.STATE, bus.HP_ME, bus.HP_OPP, bus.ROUND_CNT);
    end
  endtask

  task automatic test_wrong_priority();
    go_input("wrong");
    bus.WRONG_IN = 1'b1; bus.JUDGE_IN = 2'b01;
    cycle();
    bus.WRONG_IN = 1'b0; bus.JUDGE_IN = 2'b00;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (bus.STATE !== 4'd7 || bus.HP_OPP !== 3'd2 || bus.HP_ME !== 3'd2) begin n_fail++; $display("FAIL wrong_hold[%0d] got=%0d/%0d/%0d exp=7/2/2", i, bus.STATE, bus.HP_ME, bus.HP_OPP); end
      cycle();
    end
    n_chk++; if (bus.STATE !== 4'd4 || bus.ROUND_CNT !== 8'd0) begin n_fail++; $display("FAIL wrong_exit got=%0d/%0d exp=4/0", bus.STATE, bus.ROUND_CNT); end
    bus.ANS_TOG = ~bus.ANS_TOG;
    cycle();
    n_chk++; if (bus.STATE !== 4'd3) begin n_fail++; $display("FAIL input_tog_back got=%0d exp=3", bus.STATE); end
  endtask

  task automatic test_reset_mid_display();
    bus.ANS_TOG = ~bus.ANS_TOG;
    cycle();
    n_chk++; if (bus.STATE !== 4'd4) begin n_fail++; $display("FAIL rstmid_input got=%0d exp=4", bus.STATE); end
    bus.JUDGE_IN = 2'b01;
    cycle();
    bus.JUDGE_IN = 2'b00;
    cycle();
    n_chk++; if (bus.STATE !== 4'd8 || bus.HP_OPP !== 3'd1) begin n_fail++; $display("FAIL rstmid_good got=%0d/%0d exp=8/1", bus.STATE, bus.HP_OPP); end
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    n_chk++; if (bus.STATE !== 4'd2 || bus.SHOWING !== 1'b0 || bus.HP_OPP !== 3'd2 || bus.HP_ME !== 3'd2 || bus.ROUND_CNT !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_after got=%0d/%b/%0d/%0d/%0d exp=2/0/2/2/0", bus.STATE, bus.SHOWING, bus.HP_ME, bus.HP_OPP, bus.ROUND_CNT);
    end
  endtask

  task automatic test_ouch_lose();
    for (int r = 1; r <= 2; r++) begin
      bus.START = 1'b1; bus.Q_READY = 1'b1;
      cycle();
      bus.START = 1'b0;
      bus.JUDGE_IN = 2'b10;
      cycle();
      // keep pushing inputs during the display: they must have no effect
      for (int i = 0; i < 4; i++) begin
        n_chk++; if (bus.STATE !== 4'd9 || bus.HP_ME !== 3'(2 - r) || bus.ROUND_CNT !== 8'(r)) begin
          n_fail++; $display("FAIL ouch%0d_hold[%0d] got=%0d/%0d/%0d exp=9/%0d/%0d", r, i, bus.STATE, bus.HP_ME, bus.ROUND_CNT, 2 - r, r);
        end
        bus.ANS_TOG = ~bus.ANS_TOG;
        bus.WRONG_IN = 1'b1;
        cycle();
      end
      bus.JUDGE_IN = 2'b00; bus.WRONG_IN = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (bus.STATE !== 4'd11) begin n_fail++; $display("FAIL lose_hold[%0d] got=%0d exp=11", i, bus.STATE); end
      cycle();
    end
    n_chk++; if (bus.STATE !== 4'd11) begin n_fail++; $display("FAIL lose_last got=%0d exp=11", bus.STATE); end
    cycle();
    n_chk++; if (bus.STATE !== 4'd2 || bus.HP_ME !== 3'd2 || bus.ROUND_CNT !== 8'd0) begin n_fail++; $display("FAIL lose_reload got=%0d/%0d/%0d exp=2/2/0", bus.STATE, bus.HP_ME, bus.ROUND_CNT); end
  endtask

  task automatic test_answer_idle();
    go_input("idle");
    for (int i = 0; i < ANS_CYC - 1; i++) cycle();
    n_chk++; if (bus.STATE !== 4'd4 || bus.TMO !== 1'b0) begin n_fail++; $display("FAIL idle_before got=%0d/%b exp=4/0", bus.STATE, bus.TMO); end
    cycle();
`ifdef ANSWER_TIMEOUT_EN
    n_chk++; if (bus.STATE !== 4'd9 || bus.TMO !== 1'b1 || bus.HP_ME !== 3'd1) begin n_fail++; $display("FAIL idle_timeout got=%0d/%b/%0d exp=9/1/1", bus.STATE, bus.TMO, bus.HP_ME); end
    cycle();
    n_chk++; if (bus.TMO !== 1'b0) begin n_fail++; $display("FAIL idle_tmo_pulse got=%b exp=0", bus.TMO); end
`else
    for (int i = 0; i < 4; i++) cycle();
    n_chk++; if (bus.STATE !== 4'd4 || bus.TMO !== 1'b0 || bus.HP_ME !== 3'd2) begin n_fail++; $display("FAIL idle_wait got=%0d/%b/%0d exp=4/0/2", bus.STATE, bus.TMO, bus.HP_ME); end
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      RST          = ($urandom_range(0, 149) == 0);
      bus.START    = 1'($urandom_range(0, 1));
      bus.Q_READY  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) bus.ANS_TOG = ~bus.ANS_TOG;
      bus.WRONG_IN = ($urandom_range(0, 7) == 0);
      bus.JUDGE_IN = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle();
      n_chk++; if (bus.STATE !== 4'(m_state)) begin n_fail++; $display("FAIL rnd_state c=%0d got=%0d exp=%0d", c, bus.STATE, m_state); end
      n_chk++; if (bus.HP_ME !== 3'(m_hp_me) || bus.HP_OPP !== 3'(m_hp_opp)) begin n_fail++; $display("FAIL rnd_hp c=%0d got=%0d/%0d exp=%0d/%0d", c, bus.HP_ME, bus.HP_OPP, m_hp_me, m_hp_opp); end
      n_chk++; if (bus.ROUND_CNT !== 8'(m_round)) begin n_fail++; $display("FAIL rnd_round c=%0d got=%0d exp=%0d", c, bus.ROUND_CNT, m_round); end
      n_chk++; if (bus.SHOWING !== (m_state >= 6) || bus.TMO !== 1'(m_tmo)) begin n_fail++; $display("FAIL rnd_flags c=%0d got=%b%b exp=%b%b", c, bus.SHOWING, bus.TMO, m_state >= 6, 1'(m_tmo)); end
    end
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b0;
    bus.START = 1'b0; bus.Q_READY = 1'b0; bus.ANS_TOG = 1'b0;
    bus.WRONG_IN = 1'b0; bus.JUDGE_IN = 2'b00;
    m_state = 2; m_hp_me = HP_MAX; m_hp_opp = HP_MAX; m_round = 0;
    m_hold = 0; m_ans = 0; m_tmo = 0; m_prev = 1'b0;
    @(negedge CLK);
    test_reset();
    test_good_win();
    test_wrong_priority();
    test_reset_mid_display();
    test_ouch_lose();
    test_answer_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
